// File: rtl/alu_ex_stage.sv
// ALU execute stage: computes result and flags for one ALU operation and holds
// them in a registered output slot with a valid/ready handshake. It supports
// backpressure and a synchronous flush.
module alu_ex_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op
);

  localparam int unsigned Msb = WIDTH - 1;

  // Operation codes produced by the ALU control decoder
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpNor = 4'b1100;

  // Datapath intermediates
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_lt;

  // Next values for the output slot
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             ovf_d;
  logic             illegal_d;

  // Output slot state
  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             illegal_q;

  // Handshake qualifiers
  logic             accept;
  logic             pop;
  logic             valid_d;

  // Shared adder/subtractor plus signed-overflow detection
  always_comb begin
    sum     = src_a + src_b;
    diff    = src_a - src_b;
    add_ovf = (src_a[Msb] == src_b[Msb]) && (sum[Msb] != src_a[Msb]);
    sub_ovf = (src_a[Msb] != src_b[Msb]) && (diff[Msb] != src_a[Msb]);
    // Correct the sign of the difference when the subtraction wrapped
    slt_lt  = diff[Msb] ^ sub_ovf;
  end

  // Select the result and flags for the presented operation
  always_comb begin
    result_d  = '0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    case (operation)
      OpAnd: result_d = src_a & src_b;
      OpOr:  result_d = src_a | src_b;
      OpAdd: begin
        result_d = sum;
        ovf_d    = add_ovf;
      end
      OpSub: begin
        result_d = diff;
        ovf_d    = sub_ovf;
      end
      OpSlt: result_d = {{(WIDTH - 1){1'b0}}, slt_lt};
      OpNor: result_d = ~(src_a | src_b);
      default: illegal_d = 1'b1;
    endcase
    zero_d = (result_d == '0);
  end

  // Handshake: ready when the slot is empty or draining this cycle, never during flush
  always_comb begin
    in_ready = !flush && (!valid_q || out_ready);
    accept   = in_valid && in_ready;
    pop      = valid_q && out_ready;
    valid_d  = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // Output valid flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Output data and flags load only on accept and otherwise hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid  = valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed steps from the test plan
// followed by randomized traffic, all compared against a behavioural model.
module tb_alu_ex_stage;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   operation;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the output slot
  logic         m_valid;
  logic [W-1:0] m_res;
  logic         m_zero;
  logic         m_ovf;
  logic         m_ill;

  always #5 clk = ~clk;

  alu_ex_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal_op(illegal_op)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU using signed integer arithmetic on wide values
  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic ov, output logic il);
    longint sa, sb, s, smax, smin;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    r    = '0;
    ov   = 1'b0;
    il   = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s  = sa + sb;
        r  = s[W-1:0];
        ov = (s > smax) || (s < smin);
      end
      4'b0110: begin
        s  = sa - sb;
        r  = s[W-1:0];
        ov = (s > smax) || (s < smin);
      end
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b1100: r = ~(a | b);
      default: il = 1'b1;
    endcase
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, m_valid);
    check("result", result, m_res);
    check("zero", zero, m_zero);
    check("overflow", overflow, m_ovf);
    check("illegal_op", illegal_op, m_ill);
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge
  task automatic cycle(input logic iv, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ordy, input logic fl);
    logic         exp_rdy, acc, pop;
    logic [W-1:0] r;
    logic         ov, il;
    in_valid  = iv;
    operation = op;
    src_a     = a;
    src_b     = b;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = !fl && (!m_valid || ordy);
    check("in_ready", in_ready, exp_rdy);
    acc = iv && exp_rdy;
    pop = m_valid && ordy;
    @(posedge clk);
    if (fl) m_valid = 1'b0;
    else if (acc) m_valid = 1'b1;
    else if (pop) m_valid = 1'b0;
    if (acc) begin
      ref_alu(op, a, b, r, ov, il);
      m_res  = r;
      m_ovf  = ov;
      m_ill  = il;
      m_zero = (r == '0);
    end
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_res   = '0;
    m_zero  = 1'b0;
    m_ovf   = 1'b0;
    m_ill   = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [3:0] legal [6];
    logic [3:0] op;
    legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    // Reset with random inputs on every port
    model_reset();
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush     = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      operation = 4'($urandom);
      src_a     = W'($urandom);
      src_b     = W'($urandom);
      @(posedge clk);
      #1;
      check_outputs();
    end
    @(negedge clk);
    rstn      = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready after reset", in_ready, 1'b1);
    check("out_valid after reset", out_valid, 1'b0);

    // Back-to-back with out_ready high
    cycle(1'b1, 4'b0010, 32'd5, 32'd7, 1'b1, 1'b0);
    check("add 5+7", result, 32'd12);
    check("add 5+7 zero", zero, 1'b0);
    cycle(1'b1, 4'b0110, 32'd3, 32'd3, 1'b1, 1'b0);
    check("sub 3-3", result, 32'd0);
    check("sub 3-3 zero", zero, 1'b1);
    check("b2b valid", out_valid, 1'b1);
    cycle(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    check("slt -1<1", result, 32'd1);
    check("b2b valid 2", out_valid, 1'b1);

    // Overflow and logic boundaries
    cycle(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
    check("add ovf result", result, 32'h8000_0000);
    check("add ovf flag", overflow, 1'b1);
    cycle(1'b1, 4'b0110, 32'h8000_0000, 32'd1, 1'b1, 1'b0);
    check("sub ovf result", result, 32'h7FFF_FFFF);
    check("sub ovf flag", overflow, 1'b1);
    cycle(1'b1, 4'b0111, 32'h8000_0000, 32'd1, 1'b1, 1'b0);
    check("slt wrap", result, 32'd1);
    check("slt ovf flag", overflow, 1'b0);
    cycle(1'b1, 4'b0111, 32'd42, 32'd42, 1'b1, 1'b0);
    check("slt equal", result, 32'd0);
    cycle(1'b1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 1'b0);
    check("and", result, 32'h0000_F000);
    cycle(1'b1, 4'b1100, 32'd0, 32'd0, 1'b1, 1'b0);
    check("nor", result, 32'hFFFF_FFFF);
    cycle(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);
    check("drain", out_valid, 1'b0);

    // Backpressure then simultaneous pop and accept
    cycle(1'b1, 4'b0001, 32'h1, 32'h2, 1'b0, 1'b0);
    check("or 1|2", result, 32'd3);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'b0010, 32'd9, 32'd9, 1'b0, 1'b0);
      check("stall result", result, 32'd3);
      check("stall valid", out_valid, 1'b1);
    end
    cycle(1'b1, 4'b0000, 32'hFF, 32'h0F, 1'b1, 1'b0);
    check("pop+accept valid", out_valid, 1'b1);
    check("pop+accept result", result, 32'h0F);

    // Flush while stalled with a valid input
    cycle(1'b1, 4'b0010, 32'd1, 32'd1, 1'b0, 1'b1);
    check("flush valid", out_valid, 1'b0);
    check("flush no load", result, 32'h0F);

    // Illegal opcode then a legal one
    cycle(1'b1, 4'b1111, 32'd9, 32'd9, 1'b1, 1'b0);
    check("illegal result", result, 32'd0);
    check("illegal zero", zero, 1'b1);
    check("illegal flag", illegal_op, 1'b1);
    cycle(1'b1, 4'b0010, 32'd1, 32'd2, 1'b1, 1'b0);
    check("illegal cleared", illegal_op, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom);
      else op = legal[$urandom_range(0, 5)];
      cycle(1'($urandom), op, pick_operand(), pick_operand(),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-transfer discards the pending result
    cycle(1'b1, 4'b0010, 32'd4, 32'd4, 1'b0, 1'b0);
    check("pre-reset valid", out_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);
    check("no replay", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute stage that sits directly downstream of the ALU control decoder.
- Takes the 4-bit ALU operation code plus two operands, computes result and flags, and holds them in a registered output slot with a valid/ready handshake.
- Supports backpressure and a pipeline flush, so it can be dropped between ID/EX and EX/MEM in the pipelined datapath.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of the stage (branch mispredict/exception).
- in_valid  input  1  upstream presents a valid operation.
- in_ready  output  1  stage can accept this cycle.
- operation  input  4  ALU operation code from ALU control.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  registered ALU result.
- zero  output  1  registered: result == 0.
- overflow  output  1  registered signed overflow (add/sub only).
- illegal_op  output  1  registered: operation code not in the supported set.

Behaviour:
- Reset (rstn low, asynchronous):
  - out_valid, result, zero, overflow and illegal_op all go to 0 immediately.
  - After release, in_ready is 1 unless flush is high.
- Operation codes:
  - 0000 AND: src_a & src_b.
  - 0001 OR: src_a | src_b.
  - 0010 add: src_a + src_b, mod 2^WIDTH.
  - 0110 sub: src_a - src_b, mod 2^WIDTH.
  - 0111 slt: signed compare; result = {WIDTH-1 zeros, lt}. lt = sign(src_a - src_b) XOR sub overflow.
  - 1100 NOR: ~(src_a | src_b).
  - Any other code: result 0, zero 1, overflow 0, illegal_op 1.
- overflow:
  - add: both operands have the same sign and the result sign differs.
  - sub: operand signs differ and the result sign differs from src_a.
  - 0 for all other operations, including slt.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready). This is combinational; no dependence on in_valid.
  - Accept = in_valid && in_ready. On accept, the computed result and flags are loaded into the output register and out_valid = 1 next cycle. Latency is 1 cycle.
  - Pop = out_valid && out_ready. A pop without accept clears out_valid next cycle. A pop with accept in the same cycle keeps out_valid = 1 and loads the new data (full throughput, one op per cycle).
  - While out_valid && !out_ready, result and all flags hold stable and in_ready = 0.
  - Output registers load only on accept. When not loading they hold their value, even when out_valid = 0.
- Flush:
  - flush high at a clock edge forces out_valid = 0 next cycle.
  - Nothing is accepted that cycle; in_ready is 0 while flush is high.
  - Data registers are not required to clear.
  - flush overrides any simultaneous pop or accept.
- Boundaries:
  - sub 0x80000000 - 1 gives overflow 1 and result 0x7FFFFFFF.
  - add 0x7FFFFFFF + 1 gives result 0x80000000 and overflow 1.
  - slt with equal operands gives 0.
  - slt across an overflowing subtraction (e.g. 0x80000000 < 1) must still give 1.
- Reset asserted mid-transfer discards the pending result. Nothing is replayed after release.

Test Plan:
- Reset: hold rstn=0 with random inputs -> all outputs 0. Release -> in_ready=1, out_valid=0.
- Back-to-back ops with out_ready=1:
  - add 5+7 -> result 12, zero 0.
  - then sub 3-3 -> result 0, zero 1.
  - then slt 0xFFFFFFFF,1 -> result 1.
  - Each appears exactly 1 cycle after accept, with out_valid continuously 1.
- Overflow:
  - add 0x7FFFFFFF+1 -> 0x80000000, overflow 1.
  - sub 0x80000000-1 -> 0x7FFFFFFF, overflow 1.
  - slt 0x80000000,1 -> 1, overflow 0.
  - AND 0xF0F0,0xFF00 -> 0xF000.
  - NOR 0,0 -> 0xFFFFFFFF.
- Backpressure:
  - Accept OR 0x1|0x2, hold out_ready=0 for 3 cycles -> result 3 stable, in_ready=0 throughout.
  - Raise out_ready together with a new valid input -> pop and accept in the same cycle, out_valid stays 1.
- Flush: while out_valid=1 and out_ready=0, pulse flush with in_valid=1 -> out_valid=0 next cycle, input not accepted, in_ready=0 during flush.
- Illegal op: operation 1111 with src_a=src_b=9 -> result 0, zero 1, illegal_op 1. A following legal op clears illegal_op.
